rr_bus_arbiter: RTL

Round-robin arbiter for the shared system bus. It grants the bus to one of N masters at a time and holds the grant for the whole transaction. It releases the bus on transaction end, on request withdrawal, or on a watchdog timeout. It replaces fixed two-master priority toggling with fair rotation and exposes debug state for the bench and the on-chip monitor.

---
 rtl/rr_bus_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter: grants one master at a time, holds the grant for the whole
// transaction, and releases on last, request withdrawal or watchdog timeout.
module rr_bus_arbiter #(
    parameter  int N_MASTERS = 4,
    parameter  int TIMEOUT   = 255,
    localparam int IDXW      = $clog2(N_MASTERS),
    localparam int CNTW      = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] req,
    input  logic                 last,
    output logic [N_MASTERS-1:0] grant,
    output logic [IDXW-1:0]      owner,
    output logic                 bus_busy,
    output logic                 timeout_err,
    output logic [1:0]           D_STATE,
    output logic [IDXW-1:0]      D_PTR
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BUSY    = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    localparam logic [N_MASTERS-1:0] GRANT_ONE = N_MASTERS'(1);
    localparam logic [CNTW-1:0]      CNT_LIMIT = CNTW'(TIMEOUT - 1);
    localparam logic [IDXW:0]        N_WIDE    = (IDXW + 1)'(N_MASTERS);

    state_t                 state_q;
    logic [N_MASTERS-1:0]   grant_q;
    logic [IDXW-1:0]        owner_q;
    logic                   bus_busy_q;
    logic                   timeout_err_q;
    logic [IDXW-1:0]        ptr_q;
    logic [CNTW-1:0]        cnt_q;

    logic [IDXW-1:0]        ptr_d;
    logic [IDXW-1:0]        sel_idx_d;
    logic                   sel_valid_d;

    // Candidate index for each offset from the pointer, wrapped explicitly so that
    // a non-power-of-two master count never selects a nonexistent requester.
    logic [IDXW:0]          cand_sum  [N_MASTERS];
    logic [IDXW-1:0]        cand_idx  [N_MASTERS];
    logic [N_MASTERS-1:0]   cand_req;

    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_cand
        assign cand_sum[gi] = {1'b0, ptr_q} + (IDXW + 1)'(gi);
        assign cand_idx[gi] = (cand_sum[gi] >= N_WIDE) ? IDXW'(cand_sum[gi] - N_WIDE)
                                                       : cand_sum[gi][IDXW-1:0];
        assign cand_req[gi] = req[cand_idx[gi]];
    end

    // Scan from the farthest offset down so the closest asserted request wins.
    always_comb begin
        sel_idx_d   = '0;
        sel_valid_d = |req;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                sel_idx_d = cand_idx[k];
            end
        end
    end

    assign ptr_d = (owner_q == IDXW'(N_MASTERS - 1)) ? '0 : owner_q + IDXW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            owner_q       <= '0;
            bus_busy_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            ptr_q         <= '0;
            cnt_q         <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    timeout_err_q <= 1'b0;
                    if (sel_valid_d) begin
                        grant_q    <= GRANT_ONE << sel_idx_d;
                        owner_q    <= sel_idx_d;
                        cnt_q      <= '0;
                        bus_busy_q <= 1'b1;
                        state_q    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A normal end of transaction outranks the watchdog in the same cycle.
                    if (last || !req[owner_q]) begin
                        grant_q       <= '0;
                        bus_busy_q    <= 1'b0;
                        timeout_err_q <= 1'b0;
                        state_q       <= ST_RELEASE;
                    end else if (cnt_q == CNT_LIMIT) begin
                        grant_q       <= '0;
                        bus_busy_q    <= 1'b0;
                        timeout_err_q <= 1'b1;
                        state_q       <= ST_RELEASE;
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                ST_RELEASE: begin
                    ptr_q         <= ptr_d;
                    timeout_err_q <= 1'b0;
                    state_q       <= ST_IDLE;
                end
                default: begin
                    grant_q       <= '0;
                    bus_busy_q    <= 1'b0;
                    timeout_err_q <= 1'b0;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign owner       = owner_q;
    assign bus_busy    = bus_busy_q;
    assign timeout_err = timeout_err_q;
    assign D_STATE     = state_q;
    assign D_PTR       = ptr_q;

endmodule
